// File: rtl/btb_update_sched.sv
// rtl/btb_update_sched.sv - BTB RAM write-port scheduler: zero sweep on reset/flush, in-order update queue
module btb_update_sched #(
    parameter int DEPTH   = 4,
    parameter int INDEX_W = 11,
    parameter int TAG_W   = 9
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   upd0_valid,
    input  logic [31:0]            upd0_pc,
    input  logic [31:0]            upd0_target,
    input  logic [1:0]             upd0_type,
    input  logic                   upd0_loc,
    output logic                   upd0_ready,

    input  logic                   upd1_valid,
    input  logic [31:0]            upd1_pc,
    input  logic [31:0]            upd1_target,
    input  logic [1:0]             upd1_type,
    input  logic                   upd1_loc,
    output logic                   upd1_ready,

    input  logic                   flush_req,

    output logic                   wr_en,
    output logic [INDEX_W-1:0]     wr_addr,
    output logic [TAG_W+34:0]      wr_data,
    output logic                   init_busy,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = TAG_W + 35;
    localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [INDEX_W-1:0] SWEEP_LAST = {INDEX_W{1'b1}};

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [INDEX_W-1:0] sweep_cnt;

    logic [INDEX_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0]  q_data [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   free;

    logic               run_ok;
    logic               ready0;
    logic               ready1;
    logic               enq0;
    logic               enq1;
    logic               deq;
    logic               do_flush;

    logic [INDEX_W-1:0] e0_addr;
    logic [INDEX_W-1:0] e1_addr;
    logic [DATA_W-1:0]  e0_data;
    logic [DATA_W-1:0]  e1_data;
    logic [PTR_W-1:0]   tail_p1;

    // Entry encoding is done at enqueue so the drain path is a plain mux.
    assign e0_addr = upd0_pc[INDEX_W+2:3];
    assign e1_addr = upd1_pc[INDEX_W+2:3];
    assign e0_data = {upd0_pc[TAG_W+8:9] ^ upd0_pc[TAG_W-1:0],
                      upd0_target, upd0_type, upd0_loc};
    assign e1_data = {upd1_pc[TAG_W+8:9] ^ upd1_pc[TAG_W-1:0],
                      upd1_target, upd1_type, upd1_loc};

    // Free space is taken from the start-of-cycle count; a same-cycle drain is not credited.
    assign free     = DEPTH_C - count;
    assign run_ok   = (state == ST_RUN) && !reset;
    assign do_flush = run_ok && flush_req;
    assign ready0   = run_ok && !flush_req && (free >= CNT_W'(1));
    assign ready1   = run_ok && !flush_req && (free >= CNT_W'(2));
    assign enq0     = upd0_valid && ready0 && (upd0_type != 2'd0);
    assign enq1     = upd1_valid && ready1 && (upd1_type != 2'd0);
    assign deq      = run_ok && (count != '0);
    assign tail_p1  = tail + PTR_W'(1);

    assign upd0_ready = ready0;
    assign upd1_ready = ready1;
    assign q_count    = reset ? '0 : count;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        init_busy  = 1'b1;
        if (!reset) begin
            case (state)
                ST_SWEEP: begin
                    wr_en   = 1'b1;
                    wr_addr = sweep_cnt;
                    if (sweep_cnt == SWEEP_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_busy = 1'b0;
                    if (count != '0) begin
                        wr_en   = 1'b1;
                        wr_addr = q_addr[head];
                        wr_data = q_data[head];
                    end
                    if (flush_req) begin
                        state_next = ST_SWEEP;
                    end
                end
                default: begin
                    state_next = ST_SWEEP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            // Counter wraps to 0 naturally after the last index, ready for the next flush.
            if (state == ST_SWEEP) begin
                sweep_cnt <= sweep_cnt + INDEX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            tail  <= tail + PTR_W'(enq0) + PTR_W'(enq1);
            count <= count + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(deq);
        end
    end

    // Queue storage holds no reset state; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq0) begin
            q_addr[tail] <= e0_addr;
            q_data[tail] <= e0_data;
        end
        if (enq1) begin
            q_addr[enq0 ? tail_p1 : tail] <= e1_addr;
            q_data[enq0 ? tail_p1 : tail] <= e1_data;
        end
    end

endmodule

// File: tb/tb_btb_update_sched.sv
// tb/tb_btb_update_sched.sv - self-checking bench for btb_update_sched against a queue-based model
module tb_btb_update_sched;

    localparam int DEPTH   = 4;
    localparam int INDEX_W = 11;
    localparam int TAG_W   = 9;
    localparam int NIDX    = 2048;

    logic        clk;
    logic        reset;
    logic        upd0_valid, upd1_valid;
    logic [31:0] upd0_pc, upd1_pc, upd0_target, upd1_target;
    logic [1:0]  upd0_type, upd1_type;
    logic        upd0_loc, upd1_loc;
    logic        upd0_ready, upd1_ready;
    logic        flush_req;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [43:0] wr_data;
    logic        init_busy;
    logic [2:0]  q_count;

    btb_update_sched #(.DEPTH(DEPTH), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_target(upd0_target),
        .upd0_type(upd0_type), .upd0_loc(upd0_loc), .upd0_ready(upd0_ready),
        .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_target(upd1_target),
        .upd1_type(upd1_type), .upd1_loc(upd1_loc), .upd1_ready(upd1_ready),
        .flush_req(flush_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_busy(init_busy), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [43:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    bit  m_sweep = 1'b1;
    int  m_pos = 0;

    logic        s_rst, s_flush, s_v0, s_v1, s_l0, s_l1;
    logic [31:0] s_pc0, s_pc1, s_t0, s_t1;
    logic [1:0]  s_ty0, s_ty1;

    function automatic wr_t encode(input logic [31:0] pc, input logic [31:0] tgt,
                                   input logic [1:0] ty, input logic lc);
        wr_t e;
        e.addr = pc[13:3];
        e.data = {pc[17:9] ^ pc[8:0], tgt, ty, lc};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_flush = 1'b0;
        s_v0 = 1'b0; s_pc0 = '0; s_t0 = '0; s_ty0 = '0; s_l0 = 1'b0;
        s_v1 = 1'b0; s_pc1 = '0; s_t1 = '0; s_ty1 = '0; s_l1 = 1'b0;
    endtask

    task automatic rand_reqs(input bit both, input bit nonzero);
        s_v0  = both ? 1'b1 : 1'($urandom_range(0, 1));
        s_v1  = both ? 1'b1 : 1'($urandom_range(0, 1));
        s_pc0 = $urandom; s_t0 = $urandom; s_l0 = 1'($urandom_range(0, 1));
        s_pc1 = $urandom; s_t1 = $urandom; s_l1 = 1'($urandom_range(0, 1));
        s_ty0 = nonzero ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
        s_ty1 = nonzero ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
    endtask

    // One clock: drive at negedge, check outputs, then advance the model at posedge.
    task automatic step();
        logic e_wr, e_busy, e_r0, e_r1;
        wr_t  e_w;
        int   sz;
        @(negedge clk);
        reset = s_rst; flush_req = s_flush;
        upd0_valid = s_v0; upd0_pc = s_pc0; upd0_target = s_t0; upd0_type = s_ty0; upd0_loc = s_l0;
        upd1_valid = s_v1; upd1_pc = s_pc1; upd1_target = s_t1; upd1_type = s_ty1; upd1_loc = s_l1;
        #1;
        sz  = sb.size();
        e_w = '0;
        if (s_rst) begin
            e_wr = 1'b0; e_busy = 1'b1; e_r0 = 1'b0; e_r1 = 1'b0; sz = 0;
        end else if (m_sweep) begin
            e_wr = 1'b1; e_busy = 1'b1; e_r0 = 1'b0; e_r1 = 1'b0;
            e_w.addr = 11'(m_pos);
        end else begin
            e_busy = 1'b0;
            e_r0 = !s_flush && (DEPTH - sz >= 1);
            e_r1 = !s_flush && (DEPTH - sz >= 2);
            e_wr = (sz != 0);
            if (e_wr) e_w = sb[0];
        end
        chk("wr_en", 64'(wr_en), 64'(e_wr));
        chk("init_busy", 64'(init_busy), 64'(e_busy));
        chk("upd0_ready", 64'(upd0_ready), 64'(e_r0));
        chk("upd1_ready", 64'(upd1_ready), 64'(e_r1));
        chk("q_count", 64'(q_count), 64'(sz));
        if (e_wr || s_rst) begin
            chk("wr_addr", 64'(wr_addr), 64'(e_w.addr));
            chk("wr_data", 64'(wr_data), 64'(e_w.data));
        end
        @(posedge clk);
        if (s_rst) begin
            sb.delete(); m_sweep = 1'b1; m_pos = 0;
        end else if (m_sweep) begin
            m_pos++;
            if (m_pos == NIDX) begin
                m_sweep = 1'b0; m_pos = 0;
            end
        end else begin
            if (e_wr) void'(sb.pop_front());
            if (s_flush) begin
                sb.delete(); m_sweep = 1'b1; m_pos = 0;
            end else begin
                if (s_v0 && e_r0 && s_ty0 != 2'd0) sb.push_back(encode(s_pc0, s_t0, s_ty0, s_l0));
                if (s_v1 && e_r1 && s_ty1 != 2'd0) sb.push_back(encode(s_pc1, s_t1, s_ty1, s_l1));
            end
        end
    endtask

    initial begin
        s_rst = 1'b1;
        idle();
        repeat (3) step();
        s_rst = 1'b0;

        // Reset sweep with requests knocking that must not be accepted.
        for (int i = 0; i < NIDX; i++) begin
            rand_reqs(1'b0, 1'b0);
            step();
        end
        idle();
        step();

        // Single update from pipe 0.
        s_v0 = 1'b1; s_pc0 = 32'h8000_1238; s_t0 = 32'h8000_4000; s_ty0 = 2'd1; s_l0 = 1'b1;
        step();
        idle();
        repeat (3) step();

        // Dual accept, pipe 0 drained first.
        s_v0 = 1'b1; s_pc0 = 32'h0000_0100; s_t0 = 32'h1111_0000; s_ty0 = 2'd3;
        s_v1 = 1'b1; s_pc1 = 32'h0000_0108; s_t1 = 32'h2222_0000; s_ty1 = 2'd3; s_l1 = 1'b1;
        step();
        idle();
        repeat (3) step();

        // Type-0 request on pipe 0 is dropped.
        s_v0 = 1'b1; s_pc0 = 32'h0000_4440; s_t0 = 32'h3333_0000; s_ty0 = 2'd0;
        s_v1 = 1'b1; s_pc1 = 32'h0000_5558; s_t1 = 32'h4444_0000; s_ty1 = 2'd2;
        step();
        idle();
        repeat (3) step();

        // Sustained dual pressure.
        for (int i = 0; i < 30; i++) begin
            rand_reqs(1'b1, 1'b1);
            step();
        end
        idle();
        repeat (6) step();

        for (int i = 0; i < 400; i++) begin
            rand_reqs(1'b0, 1'b0);
            step();
        end
        idle();
        repeat (6) step();

        // Build occupancy to 3 then flush with requests present.
        rand_reqs(1'b1, 1'b1); step();
        rand_reqs(1'b1, 1'b1); step();
        rand_reqs(1'b1, 1'b1); s_flush = 1'b1; step();
        idle();

        for (int i = 0; i < 500; i++) begin
            rand_reqs(1'b0, 1'b0);
            step();
        end
        s_flush = 1'b1; step();
        s_flush = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rand_reqs(1'b0, 1'b0);
            step();
        end

        // Reset mid-sweep restarts from address 0.
        idle();
        s_rst = 1'b1;
        repeat (2) step();
        s_rst = 1'b0;
        for (int i = 0; i < NIDX; i++) begin
            rand_reqs(1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 200; i++) begin
            rand_reqs(1'b0, 1'b0);
            step();
        end
        idle();
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
